mmio_io_responder: RTL and testbench
====================================

Name: mmio_io_responder

Overview:
- Memory-mapped I/O responder at the far end of the MEM-stage data bus (address = malu, write data = mb, write enable = mwmem).
- Answers CPU loads and stores in a fixed window.
- Drives six active-low 7-segment displays from CPU-written nibbles.
- Presents the 10 board switches to the CPU after synchronisation and debounce, with a sticky change flag and an event counter.

Parameters:
- IO_BASE, 32'h0000_00C0, byte base of the 32-byte I/O window (32-byte aligned).
- DEBOUNCE_CYCLES, 16'd50000, consecutive stable cycles required before the debounced switch value updates; minimum 2.

Ports:
- clock  in  1  system clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- addr  in  32  byte address from the MEM stage; bits [1:0] ignored.
- wdata  in  32  store data.
- we  in  1  store strobe; one write per cycle when high.
- rdata  out  32  load data, combinational from internal registers.
- sel  out  1  high when addr is inside [IO_BASE, IO_BASE+0x1F].
- sw  in  10  raw asynchronous switch inputs.
- hex0..hex5  out  7 each  segment outputs, active-low; bit 6 = segment g.

Behaviour:
- Register map (offset from IO_BASE):
  - 0x00 HEX_LO, R/W: [15:0] = nibbles for hex3..hex0, with hex0 = [3:0].
  - 0x04 HEX_HI, R/W: [7:0] = nibbles for hex5..hex4.
  - 0x08 SW, RO: [9:0] = debounced switches.
  - 0x0C CTRL:
    - bit0 BLANK, R/W.
    - bit1 CHG, R, W1C; set on any debounced change.
  - 0x10 EVT, RO: [15:0] = debounced-change count; wraps 0xFFFF -> 0x0000.
  - 0x14..0x1C reserved: read 0, writes ignored.
- Unused bits of every register read 0.
- Writes to RO registers are ignored.
- Outside the window: sel=0, rdata=0, writes ignored.
- Write timing: a write is captured on the edge where we=1 and sel=1. The new value is readable, and visible on hex outputs, immediately after that edge.
- Read timing: rdata is valid in the same cycle as addr; there are no read side effects.
- Hex outputs:
  - Combinational seven-segment decode of the registered nibbles, 0-F, active-low.
  - Example codes: 0 -> 7'h40, 8 -> 7'h00, F -> 7'h0E.
  - When BLANK=1, all hex outputs = 7'h7F; the nibble registers are preserved.
- Switch path:
  - Two-flop synchroniser; its output is s.
  - Registers: last (10b), cnt (16b, saturates at DEBOUNCE_CYCLES-1), deb (10b).
  - Each edge:
    - If s != last: last <= s, cnt <= 0.
    - Else if cnt == DEBOUNCE_CYCLES-1 and deb != last: deb <= last, CHG <= 1, EVT <= EVT+1.
    - Else if cnt != DEBOUNCE_CYCLES-1: cnt <= cnt+1.
  - Resulting latency: a sw change held constant and first sampled at edge 0 appears in deb after edge DEBOUNCE_CYCLES+2.
  - A glitch shorter than DEBOUNCE_CYCLES stable cycles never updates deb.
- Simultaneous events:
  - CHG set and W1C in the same edge: set wins (CHG=1).
  - EVT increment and reset in the same edge: reset wins.
  - Reset asserted mid-debounce discards the pending change.
- Reset values:
  - HEX_LO=0, HEX_HI=0, BLANK=0, CHG=0, EVT=0.
  - Synchroniser, last, cnt and deb all 0.
  - Therefore hex0..hex5 = 7'h40 and rdata = 0 for in-window reads after reset.

Decomposition:
- Shared package io_map_pkg holds:
  - register offsets OFF_HEX_LO/OFF_HEX_HI/OFF_SW/OFF_CTRL/OFF_EVT;
  - CTRL bit indices;
  - the IO_BASE default.
- One sub-module, seg7_decoder: 4-bit in, 7-bit active-low out, purely combinational, instantiated six times.
- Synchroniser, debounce and register file stay in the top module.

Test Plan:
- Reset: hold reset 3 cycles. Expect:
  - hex0..hex5 = 7'h40;
  - reads of 0x00/0x04/0x08/0x0C/0x10 return 0;
  - sel=1 at addr 0xC8, sel=0 at addr 0xE0.
- Hex write: store 0x0000_8F3A to 0xC0 and 0x0000_0021 to 0xC4. Expect:
  - hex0=Ah code, hex1=3, hex2=F (7'h0E), hex3=8 (7'h00), hex4=1, hex5=2;
  - readback returns exactly those values.
  - Then write CTRL=1: all hex = 7'h7F. Write CTRL=0: digits return.
- Debounce (DEBOUNCE_CYCLES=4): set sw=10'h2A5 and hold. Expect:
  - SW reads 0 through edge 5 and 10'h2A5 after edge 6;
  - CTRL.CHG=1, EVT=1.
  - A 3-cycle sw pulse then leaves SW, CHG and EVT unchanged.
- W1C race: write CTRL=2 on the same edge a debounced change commits. Expect CHG=1 afterwards; a second write CTRL=2 with no change clears it (CHG=0).
- Out-of-window and read-only: store 0xFFFF_FFFF to 0xE0, 0xC8 and 0xD0. Expect no register change, sel=0 for 0xE0, EVT unchanged.
- EVT wrap: force 65536 debounced toggles (DEBOUNCE_CYCLES=2). Expect EVT = 0x0000 after the last toggle and 0x0001 after the next one.

Source files
------------

// File: rtl/io_map_pkg.sv
// Shared register map and constants for the MMIO I/O responder.
package io_map_pkg;

  localparam logic [31:0] IO_BASE_DEFAULT = 32'h0000_00C0;

  // Byte offsets inside the 32-byte window.
  localparam logic [4:0] OFF_HEX_LO = 5'h00;
  localparam logic [4:0] OFF_HEX_HI = 5'h04;
  localparam logic [4:0] OFF_SW     = 5'h08;
  localparam logic [4:0] OFF_CTRL   = 5'h0C;
  localparam logic [4:0] OFF_EVT    = 5'h10;

  localparam int CTRL_BLANK = 0;
  localparam int CTRL_CHG   = 1;

  localparam logic [6:0] SEG_BLANK = 7'h7F;

endpackage

// File: rtl/seg7_decoder.sv
// Hex nibble to active-low seven-segment pattern, bit 6 = segment g.
module seg7_decoder (
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  // NOTE: assign a default before the case so no path through always_comb leaves seg unassigned (no latch).
  always_comb begin
    seg = 7'h7F;
    case (nibble)
      4'h0: seg = 7'h40;
      4'h1: seg = 7'h79;
      4'h2: seg = 7'h24;
      4'h3: seg = 7'h30;
      4'h4: seg = 7'h19;
      4'h5: seg = 7'h12;
      4'h6: seg = 7'h02;
      4'h7: seg = 7'h78;
      4'h8: seg = 7'h00;
      4'h9: seg = 7'h10;
      4'hA: seg = 7'h08;
      4'hB: seg = 7'h03;
      4'hC: seg = 7'h46;
      4'hD: seg = 7'h21;
      4'hE: seg = 7'h06;
      4'hF: seg = 7'h0E;
      default: seg = 7'h7F;
    endcase
  end

endmodule

// File: rtl/mmio_io_responder.sv
// MEM-stage I/O responder: hex display registers, debounced switches with
// sticky change flag and event counter, in a 32-byte window at IO_BASE.
module mmio_io_responder
  import io_map_pkg::*;
#(
  parameter logic [31:0] IO_BASE         = IO_BASE_DEFAULT,
  parameter logic [15:0] DEBOUNCE_CYCLES = 16'd50000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic        we,
  output logic [31:0] rdata,
  output logic        sel,
  input  logic [9:0]  sw,
  output logic [6:0]  hex0,
  output logic [6:0]  hex1,
  output logic [6:0]  hex2,
  output logic [6:0]  hex3,
  output logic [6:0]  hex4,
  output logic [6:0]  hex5
);

  localparam logic [15:0] CNT_MAX = DEBOUNCE_CYCLES - 16'd1;

  logic [4:0]  off;
  logic        wr_en;
  logic [15:0] hex_lo;
  logic [7:0]  hex_hi;
  logic        blank;
  logic        chg;
  logic [15:0] evt;

  logic [9:0]  sync_a;
  logic [9:0]  sync_s;
  logic [9:0]  last;
  logic [15:0] cnt;
  logic [9:0]  deb;
  logic        commit;

  logic unused_bits;
  assign unused_bits = ^{addr[1:0], wdata[31:16]};

  assign sel   = (addr[31:5] == IO_BASE[31:5]);
  assign off   = {addr[4:2], 2'b00};
  assign wr_en = we && sel;

  // A debounced change lands when the sampled value has been stable long enough.
  assign commit = (sync_s == last) && (cnt == CNT_MAX) && (deb != last);

  // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clock) begin
    if (reset) begin
      sync_a <= '0;
      sync_s <= '0;
      last   <= '0;
      cnt    <= '0;
      deb    <= '0;
    end else begin
      sync_a <= sw;
      sync_s <= sync_a;
      if (sync_s != last) begin
        last <= sync_s;
        cnt  <= '0;
      end else if (cnt == CNT_MAX) begin
        if (deb != last) deb <= last;
      end else begin
        cnt <= cnt + 16'd1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      hex_lo <= '0;
      hex_hi <= '0;
      blank  <= 1'b0;
      chg    <= 1'b0;
      evt    <= '0;
    end else begin
      if (wr_en && off == OFF_HEX_LO) hex_lo <= wdata[15:0];
      if (wr_en && off == OFF_HEX_HI) hex_hi <= wdata[7:0];
      if (wr_en && off == OFF_CTRL)   blank  <= wdata[CTRL_BLANK];
      // A new change outranks a same-cycle write-one-to-clear.
      if (commit)
        chg <= 1'b1;
      else if (wr_en && off == OFF_CTRL && wdata[CTRL_CHG])
        chg <= 1'b0;
      if (commit) evt <= evt + 16'd1;
    end
  end

  always_comb begin
    rdata = '0;
    if (sel) begin
      case (off)
        OFF_HEX_LO: rdata[15:0] = hex_lo;
        OFF_HEX_HI: rdata[7:0]  = hex_hi;
        OFF_SW:     rdata[9:0]  = deb;
        OFF_CTRL: begin
          rdata[CTRL_BLANK] = blank;
          rdata[CTRL_CHG]   = chg;
        end
        OFF_EVT:    rdata[15:0] = evt;
        default:    rdata = '0;
      endcase
    end
  end

  logic [23:0] nibbles;
  logic [6:0]  seg [6];

  assign nibbles = {hex_hi, hex_lo};

  for (genvar g = 0; g < 6; g++) begin : g_dec
    seg7_decoder u_dec (
      .nibble (nibbles[4*g +: 4]),
      .seg    (seg[g])
    );
  end

  assign hex0 = blank ? SEG_BLANK : seg[0];
  assign hex1 = blank ? SEG_BLANK : seg[1];
  assign hex2 = blank ? SEG_BLANK : seg[2];
  assign hex3 = blank ? SEG_BLANK : seg[3];
  assign hex4 = blank ? SEG_BLANK : seg[4];
  assign hex5 = blank ? SEG_BLANK : seg[5];

endmodule

// File: tb/tb_mmio_io_responder.sv
// Directed bench: one responder with a short debounce for register/timing
// checks, a second with the minimum debounce to drive EVT through its wrap.
module tb_mmio_io_responder;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] addr  = '0;
  logic [31:0] wdata = '0;
  logic        we    = 1'b0;
  logic [9:0]  sw    = '0;
  logic [31:0] rdata;
  logic        sel;
  logic [6:0]  hex0, hex1, hex2, hex3, hex4, hex5;

  logic [31:0] addr2 = 32'h0000_00D0;
  logic [9:0]  sw2   = '0;
  logic [31:0] rdata2;
  logic        sel2;
  logic [6:0]  d2h0, d2h1, d2h2, d2h3, d2h4, d2h5;

  int vectors     = 0;
  int miscompares = 0;

  always #5 clock = ~clock;

  mmio_io_responder #(.IO_BASE(32'h0000_00C0), .DEBOUNCE_CYCLES(16'd4)) dut (
    .clock (clock), .reset (reset), .addr (addr), .wdata (wdata), .we (we),
    .rdata (rdata), .sel (sel), .sw (sw),
    .hex0 (hex0), .hex1 (hex1), .hex2 (hex2), .hex3 (hex3), .hex4 (hex4), .hex5 (hex5)
  );

  mmio_io_responder #(.IO_BASE(32'h0000_00C0), .DEBOUNCE_CYCLES(16'd2)) dut_wrap (
    .clock (clock), .reset (reset), .addr (addr2), .wdata (32'h0), .we (1'b0),
    .rdata (rdata2), .sel (sel2), .sw (sw2),
    .hex0 (d2h0), .hex1 (d2h1), .hex2 (d2h2), .hex3 (d2h3), .hex4 (d2h4), .hex5 (d2h5)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Combinational read, issued in the low half of the clock.
  task automatic check_rd(input string tag, input logic [31:0] a, input logic [31:0] exp);
    addr = a;
    we   = 1'b0;
    #1;
    check(tag, rdata, exp);
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    @(negedge clock);
    addr  = a;
    wdata = d;
    we    = 1'b1;
    @(negedge clock);
    we    = 1'b0;
  endtask

  task automatic check_hex(input string tag, input logic [6:0] e0, input logic [6:0] e1,
                           input logic [6:0] e2, input logic [6:0] e3,
                           input logic [6:0] e4, input logic [6:0] e5);
    #1;
    check({tag, "_hex0"}, {25'd0, hex0}, {25'd0, e0});
    check({tag, "_hex1"}, {25'd0, hex1}, {25'd0, e1});
    check({tag, "_hex2"}, {25'd0, hex2}, {25'd0, e2});
    check({tag, "_hex3"}, {25'd0, hex3}, {25'd0, e3});
    check({tag, "_hex4"}, {25'd0, hex4}, {25'd0, e4});
    check({tag, "_hex5"}, {25'd0, hex5}, {25'd0, e5});
  endtask

  task automatic toggle_wrap_sw();
    @(negedge clock);
    sw2[0] = ~sw2[0];
    repeat (2) @(negedge clock);
  endtask

  initial begin
    // Reset
    repeat (3) @(negedge clock);
    reset = 1'b0;
    check_hex("rst", 7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40);
    check_rd("rst_hex_lo", 32'hC0, 32'h0);
    check_rd("rst_hex_hi", 32'hC4, 32'h0);
    check_rd("rst_sw",     32'hC8, 32'h0);
    check_rd("rst_ctrl",   32'hCC, 32'h0);
    check_rd("rst_evt",    32'hD0, 32'h0);
    addr = 32'hC8; #1;
    check("sel_in", {31'd0, sel}, 32'd1);
    addr = 32'hE0; #1;
    check("sel_out", {31'd0, sel}, 32'd0);

    // Hex registers, with junk in unused upper bits of HEX_HI
    wr(32'hC0, 32'h0000_8F3A);
    wr(32'hC4, 32'hFFFF_FF21);
    check_hex("digits", 7'h08, 7'h30, 7'h0E, 7'h00, 7'h79, 7'h24);
    check_rd("rb_hex_lo", 32'hC0, 32'h0000_8F3A);
    check_rd("rb_hex_hi", 32'hC4, 32'h0000_0021);
    wr(32'hCC, 32'h1);
    check_hex("blank", 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F);
    check_rd("blank_ctrl",   32'hCC, 32'h1);
    check_rd("blank_hex_lo", 32'hC0, 32'h0000_8F3A);
    wr(32'hCC, 32'h0);
    check_hex("unblank", 7'h08, 7'h30, 7'h0E, 7'h00, 7'h79, 7'h24);

    // Debounce latency: sw first sampled at edge 0, visible after edge 6
    @(negedge clock);
    sw = 10'h2A5;
    for (int i = 0; i < 6; i++) begin
      @(negedge clock);
      check_rd($sformatf("sw_edge%0d", i), 32'hC8, 32'h0);
    end
    @(negedge clock);
    check_rd("sw_edge6", 32'hC8, 32'h0000_02A5);
    check_rd("chg_set",  32'hCC, 32'h2);
    check_rd("evt_one",  32'hD0, 32'h1);

    // Three-cycle glitch is filtered
    @(negedge clock);
    sw = 10'h000;
    repeat (2) @(negedge clock);
    @(negedge clock);
    sw = 10'h2A5;
    repeat (12) @(negedge clock);
    check_rd("glitch_sw",   32'hC8, 32'h0000_02A5);
    check_rd("glitch_ctrl", 32'hCC, 32'h2);
    check_rd("glitch_evt",  32'hD0, 32'h1);

    // W1C clears, then races a commit and loses
    wr(32'hCC, 32'h2);
    check_rd("w1c_clear", 32'hCC, 32'h0);
    @(negedge clock);
    sw = 10'h155;
    repeat (6) @(negedge clock);
    check_rd("race_pre_sw", 32'hC8, 32'h0000_02A5);
    addr  = 32'hCC;
    wdata = 32'h2;
    we    = 1'b1;
    @(negedge clock);
    we = 1'b0;
    check_rd("race_chg", 32'hCC, 32'h2);
    check_rd("race_sw",  32'hC8, 32'h0000_0155);
    check_rd("race_evt", 32'hD0, 32'h2);
    wr(32'hCC, 32'h2);
    check_rd("w1c_again", 32'hCC, 32'h0);

    // Out-of-window, read-only and reserved writes are ignored
    addr = 32'hE0; #1;
    check("oow_sel",   {31'd0, sel}, 32'd0);
    check("oow_rdata", rdata, 32'h0);
    wr(32'hE0, 32'hFFFF_FFFF);
    wr(32'hC8, 32'hFFFF_FFFF);
    wr(32'hD0, 32'hFFFF_FFFF);
    wr(32'hD4, 32'hFFFF_FFFF);
    check_rd("ro_hex_lo", 32'hC0, 32'h0000_8F3A);
    check_rd("ro_hex_hi", 32'hC4, 32'h0000_0021);
    check_rd("ro_sw",     32'hC8, 32'h0000_0155);
    check_rd("ro_ctrl",   32'hCC, 32'h0);
    check_rd("ro_evt",    32'hD0, 32'h2);
    check_rd("rsvd_d4",   32'hD4, 32'h0);
    check_rd("rsvd_dc",   32'hDC, 32'h0);
    check_hex("ro", 7'h08, 7'h30, 7'h0E, 7'h00, 7'h79, 7'h24);

    // EVT wrap on the minimum-debounce instance (reads EVT continuously)
    for (int i = 0; i < 65535; i++) toggle_wrap_sw();
    repeat (6) @(negedge clock);
    #1;
    check("evt_ffff", rdata2, 32'h0000_FFFF);
    toggle_wrap_sw();
    repeat (6) @(negedge clock);
    #1;
    check("evt_wrap", rdata2, 32'h0000_0000);
    toggle_wrap_sw();
    repeat (6) @(negedge clock);
    #1;
    check("evt_after_wrap", rdata2, 32'h0000_0001);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
